gate_exerciser: RTL

GATE_EXERCISER -- requirements
Module: gate_exerciser

---
 rtl/gate_test_pkg.sv | 22 ++
 rtl/gate_exerciser_if.sv | 23 ++
 rtl/gate_exerciser_settle_counter.sv | 23 ++
 rtl/gate_exerciser.sv | 131 +++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM states, settle default and gate truth tables for gate_exerciser
package gate_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int         DEFAULT_SETTLE = 2;
    localparam logic [3:0] TRUTH_AND      = 4'b1000;
    localparam logic [3:0] TRUTH_OR       = 4'b1110;
    localparam logic [3:0] TRUTH_NAND     = 4'b0111;
    localparam logic [3:0] TRUTH_XOR      = 4'b0110;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
    endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if: control, gate-drive and result signals between a tester and the gate under test
interface gate_exerciser_if;
    logic       start;
    logic       abort;
    logic       gate_out;
    logic       in_a;
    logic       in_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] result_vec;

    modport master (
        output start, abort, gate_out,
        input  in_a, in_b, busy, done, pass, err_cnt, result_vec
    );

    modport slave (
        input  start, abort, gate_out,
        output in_a, in_b, busy, done, pass, err_cnt, result_vec
    );
endinterface

// File: rtl/gate_exerciser_settle_counter.sv
// settle_counter: loadable down-counter with zero flag that times how long each vector is held
module settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the count never goes below zero
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    // Counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: applies all four input vectors to a two-input gate and checks it against TRUTH
// Optional per-vector capture of gate_out into result_vec: define GATE_EXERCISER_CAPTURE_EN
module gate_exerciser
    import gate_test_pkg::*;
#(
    parameter int         SETTLE = DEFAULT_SETTLE,
    parameter logic [3:0] TRUTH  = TRUTH_AND
) (
    input logic             clk,
    input logic             rst_n,
    gate_exerciser_if.slave bus
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       in_a_q, in_a_d;
    logic       in_b_q, in_b_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic       load, dec, zero;
`ifdef GATE_EXERCISER_CAPTURE_EN
    logic [3:0] res_q, res_d;
`endif

    settle_counter #(.W(4)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .val_i  (SETTLE_LOAD),
        .dec_i  (dec),
        .zero_o (zero)
    );

    // Next-state and datapath: abort from any active state wins over normal sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_a_d  = in_a_q;
        in_b_d  = in_b_q;
        pass_d  = pass_q;
        err_d   = err_q;
        load    = 1'b0;
        dec     = 1'b0;
`ifdef GATE_EXERCISER_CAPTURE_EN
        res_d   = res_q;
`endif
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            in_a_d  = 1'b0;
            in_b_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start && !bus.abort) begin
                    err_d   = '0;
                    idx_d   = '0;
                    state_d = S_DRIVE;
`ifdef GATE_EXERCISER_CAPTURE_EN
                    res_d   = '0;
`endif
                end
                S_DRIVE: begin
                    in_a_d  = idx_q[0];
                    in_b_d  = idx_q[1];
                    load    = 1'b1;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    dec     = 1'b1;
                    state_d = zero ? S_CHECK : S_SETTLE;
                end
                S_CHECK: begin
                    if (bus.gate_out != TRUTH[idx_q]) err_d = sat_inc(err_q);
`ifdef GATE_EXERCISER_CAPTURE_EN
                    res_d[idx_q] = bus.gate_out;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        in_a_d  = 1'b0;
                        in_b_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_DRIVE;
                    end
                end
                S_DONE: begin
                    pass_d  = err_q == 3'd0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            in_a_q  <= 1'b0;
            in_b_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end

`ifdef GATE_EXERCISER_CAPTURE_EN
    // Captured gate responses, one bit per vector
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;

    assign bus.result_vec = res_q;
`else
    assign bus.result_vec = '0;
`endif

    assign bus.in_a    = in_a_q;
    assign bus.in_b    = in_b_q;
    assign bus.busy    = state_q != S_IDLE;
    assign bus.done    = state_q == S_DONE && !bus.abort;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
endmodule
